// File: rtl/sw_pkg.sv
// -----------------------------------------------------------------------------
// sw_pkg
// Shared definitions for the Smith-Waterman core and its front-end arbiter:
// sequence/score limits, job and result record types, the arbiter state
// encoding and a small length-legality helper.
// -----------------------------------------------------------------------------
package sw_pkg;

    localparam int REF_MAX_LENGTH        = 128;
    localparam int READ_MAX_LENGTH       = 128;
    localparam int DP_SW_SCORE_BITWIDTH  = 10;

    // Derived widths for the default core configuration.
    localparam int SW_SEQ_WIDTH = 2 * REF_MAX_LENGTH;          // 2 bits per base
    localparam int SW_LEN_WIDTH = $clog2(REF_MAX_LENGTH) + 1;  // holds MAX_LEN itself
    localparam int SW_POS_WIDTH = $clog2(REF_MAX_LENGTH);

    typedef struct packed {
        logic [SW_SEQ_WIDTH-1:0] ref_seq;
        logic [SW_SEQ_WIDTH-1:0] read_seq;
        logic [SW_LEN_WIDTH-1:0] ref_len;
        logic [SW_LEN_WIDTH-1:0] read_len;
    } sw_job_t;

    typedef struct packed {
        logic [DP_SW_SCORE_BITWIDTH-1:0] score;
        logic [SW_POS_WIDTH-1:0]         row;
        logic [SW_POS_WIDTH-1:0]         col;
        logic                            err;
    } sw_result_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // waiting for a requester
        ST_ISSUE = 2'd1,  // presenting the latched job to the core
        ST_WAIT  = 2'd2,  // core is computing
        ST_RESP  = 2'd3   // result held for the granted requester
    } arb_state_t;

    // A length is usable by the core only if it is 1..max_len bases.
    function automatic logic len_is_legal(input int len, input int max_len);
        return (len > 0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/sw_rr_picker.sv
// -----------------------------------------------------------------------------
// sw_rr_picker
// Combinational round-robin priority select. Scans i_req starting at i_ptr and
// wrapping modulo NUM_REQ; the first set bit wins.
//
// Ports:
//   i_req   [NUM_REQ-1:0]  request vector
//   i_ptr   [IDX_W-1:0]    highest-priority index this cycle
//   o_grant [NUM_REQ-1:0]  one-hot winner (zero when no request)
//   o_idx   [IDX_W-1:0]    binary index of the winner (0 when no request)
//   o_any                  at least one request is set
// -----------------------------------------------------------------------------
module sw_rr_picker
    import sw_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_any && i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
                o_any                                  = 1'b1;
                o_grant[(int'(i_ptr) + k) % NUM_REQ]   = 1'b1;
                o_idx                                  = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/sw_core_arbiter.sv
// -----------------------------------------------------------------------------
// sw_core_arbiter
// Shares one SW_core among NUM_REQ requesters. Grants jobs round-robin, latches
// the winner's sequences and lengths, drives the core handshake, captures the
// result and returns it to the granted requester only. One job in flight.
// Jobs with an illegal length never reach the core and are answered with
// rsp_err=1 and a zero result.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready [NUM_REQ]      job handshake per requester
//   req_ref/req_read                   packed sequences, SEQ_WIDTH per requester
//   req_ref_len/req_read_len           lengths, LEN_WIDTH per requester
//   rsp_valid/rsp_ready [NUM_REQ]      result handshake per requester
//   rsp_score/row/col/err              shared result bus
//   core_i_valid/core_o_ready          job handshake to the core
//   core_ref/read/ref_len/read_len     latched job payload
//   core_i_ready/core_o_valid          result handshake from the core
//   core_score/row/col                 core result
//   busy                               not idle
//   grant_id                           current or last grantee
// -----------------------------------------------------------------------------
module sw_core_arbiter
    import sw_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int SEQ_WIDTH   = SW_SEQ_WIDTH,
    parameter int LEN_WIDTH   = SW_LEN_WIDTH,
    parameter int MAX_LEN     = REF_MAX_LENGTH,
    parameter int POS_WIDTH   = SW_POS_WIDTH,
    parameter int SCORE_WIDTH = DP_SW_SCORE_BITWIDTH,
    parameter int IDX_W       = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*SEQ_WIDTH-1:0]   req_ref,
    input  logic [NUM_REQ*SEQ_WIDTH-1:0]   req_read,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]   req_ref_len,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]   req_read_len,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [SCORE_WIDTH-1:0]         rsp_score,
    output logic [POS_WIDTH-1:0]           rsp_row,
    output logic [POS_WIDTH-1:0]           rsp_col,
    output logic                           rsp_err,
    output logic                           core_i_valid,
    input  logic                           core_o_ready,
    output logic [SEQ_WIDTH-1:0]           core_ref,
    output logic [SEQ_WIDTH-1:0]           core_read,
    output logic [LEN_WIDTH-1:0]           core_ref_len,
    output logic [LEN_WIDTH-1:0]           core_read_len,
    output logic                           core_i_ready,
    input  logic                           core_o_valid,
    input  logic [SCORE_WIDTH-1:0]         core_score,
    input  logic [POS_WIDTH-1:0]           core_row,
    input  logic [POS_WIDTH-1:0]           core_col,
    output logic                           busy,
    output logic [IDX_W-1:0]               grant_id
);

    arb_state_t r_state;
    arb_state_t w_next_state;

    logic [IDX_W-1:0]       r_rr_ptr;
    logic [IDX_W-1:0]       r_grant_id;
    logic [SEQ_WIDTH-1:0]   r_ref;
    logic [SEQ_WIDTH-1:0]   r_read;
    logic [LEN_WIDTH-1:0]   r_ref_len;
    logic [LEN_WIDTH-1:0]   r_read_len;
    logic [SCORE_WIDTH-1:0] r_score;
    logic [POS_WIDTH-1:0]   r_row;
    logic [POS_WIDTH-1:0]   r_col;
    logic                   r_err;

    logic [NUM_REQ-1:0]     w_pick_grant;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_pick_any;
    logic [LEN_WIDTH-1:0]   w_sel_ref_len;
    logic [LEN_WIDTH-1:0]   w_sel_read_len;
    logic                   w_len_err;
    logic                   w_accept;
    logic                   w_capture;
    logic                   w_rsp_done;

    sw_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_sel_ref_len  = req_ref_len [int'(w_pick_idx)*LEN_WIDTH +: LEN_WIDTH];
    assign w_sel_read_len = req_read_len[int'(w_pick_idx)*LEN_WIDTH +: LEN_WIDTH];
    assign w_len_err      = !len_is_legal(int'(w_sel_ref_len), MAX_LEN) ||
                            !len_is_legal(int'(w_sel_read_len), MAX_LEN);

    // req_ready is driven straight from the picker, so a request is accepted
    // in the same cycle the grant is shown.
    assign w_accept   = (r_state == ST_IDLE) && w_pick_any;
    assign w_capture  = (r_state == ST_WAIT) && core_o_valid;
    assign w_rsp_done = (r_state == ST_RESP) && rsp_ready[r_grant_id];

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = '0;
        core_i_valid = 1'b0;
        core_i_ready = 1'b0;
        rsp_valid    = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = w_pick_grant;
                if (w_pick_any) begin
                    w_next_state = w_len_err ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                core_i_valid = 1'b1;
                if (core_o_ready) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                core_i_ready = 1'b1;
                if (core_o_valid) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid[r_grant_id] = 1'b1;
                if (rsp_ready[r_grant_id]) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the wide payload and result registers are reset as well, so
        // core_* and rsp_* read as zero after reset instead of X.
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_ref      <= '0;
            r_read     <= '0;
            r_ref_len  <= '0;
            r_read_len <= '0;
            r_score    <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_grant_id <= w_pick_idx;
                r_ref      <= req_ref [int'(w_pick_idx)*SEQ_WIDTH +: SEQ_WIDTH];
                r_read     <= req_read[int'(w_pick_idx)*SEQ_WIDTH +: SEQ_WIDTH];
                r_ref_len  <= w_sel_ref_len;
                r_read_len <= w_sel_read_len;
                r_score    <= '0;
                r_row      <= '0;
                r_col      <= '0;
                r_err      <= w_len_err;
            end
            if (w_capture) begin
                // Bit-for-bit copy keeps the two's-complement sign intact.
                r_score <= core_score;
                r_row   <= core_row;
                r_col   <= core_col;
            end
            if (w_rsp_done) begin
                r_rr_ptr <= (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0
                                                                : r_grant_id + IDX_W'(1);
            end
        end
    end

    assign core_ref      = r_ref;
    assign core_read     = r_read;
    assign core_ref_len  = r_ref_len;
    assign core_read_len = r_read_len;
    assign rsp_score     = r_score;
    assign rsp_row       = r_row;
    assign rsp_col       = r_col;
    assign rsp_err       = r_err;
    assign busy          = (r_state != ST_IDLE);
    assign grant_id      = r_grant_id;

endmodule

// File: tb/tb_sw_core_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sw_core_arbiter
// Directed stimulus acting as requesters and as the core. A transaction-level
// model (who owns the core, what was latched, whose turn is next) predicts the
// outputs and is compared on every falling edge; literal expectations from the
// hand-worked scenarios pin the model.
// -----------------------------------------------------------------------------
module tb_sw_core_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int SEQ_WIDTH   = 256;
    localparam int LEN_WIDTH   = 8;
    localparam int MAX_LEN     = 128;
    localparam int POS_WIDTH   = 7;
    localparam int SCORE_WIDTH = 10;
    localparam int IDX_W       = 2;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic [NUM_REQ-1:0]           req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NUM_REQ*SEQ_WIDTH-1:0] req_ref, req_read;
    logic [NUM_REQ*LEN_WIDTH-1:0] req_ref_len, req_read_len;
    logic [SCORE_WIDTH-1:0]       rsp_score, core_score;
    logic [POS_WIDTH-1:0]         rsp_row, rsp_col, core_row, core_col;
    logic                         rsp_err, core_i_valid, core_o_ready;
    logic                         core_i_ready, core_o_valid, busy;
    logic [SEQ_WIDTH-1:0]         core_ref, core_read;
    logic [LEN_WIDTH-1:0]         core_ref_len, core_read_len;
    logic [IDX_W-1:0]             grant_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sw_core_arbiter #(
        .NUM_REQ(NUM_REQ), .SEQ_WIDTH(SEQ_WIDTH), .LEN_WIDTH(LEN_WIDTH),
        .MAX_LEN(MAX_LEN), .POS_WIDTH(POS_WIDTH), .SCORE_WIDTH(SCORE_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ref(req_ref), .req_read(req_read),
        .req_ref_len(req_ref_len), .req_read_len(req_read_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_score(rsp_score), .rsp_row(rsp_row), .rsp_col(rsp_col), .rsp_err(rsp_err),
        .core_i_valid(core_i_valid), .core_o_ready(core_o_ready),
        .core_ref(core_ref), .core_read(core_read),
        .core_ref_len(core_ref_len), .core_read_len(core_read_len),
        .core_i_ready(core_i_ready), .core_o_valid(core_o_valid),
        .core_score(core_score), .core_row(core_row), .core_col(core_col),
        .busy(busy), .grant_id(grant_id)
    );

    task automatic check(input string name, input logic [SEQ_WIDTH-1:0] act,
                         input logic [SEQ_WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // m_stage: 0 nobody owns the core, 1 job offered to core, 2 core computing,
    // 3 result owed to requester m_gid.
    int                     m_stage, m_ptr, m_gid;
    logic [SEQ_WIDTH-1:0]   m_ref, m_read;
    logic [LEN_WIDTH-1:0]   m_rl, m_dl;
    logic [SCORE_WIDTH-1:0] m_score;
    logic [POS_WIDTH-1:0]   m_row, m_col;
    logic                   m_err;
    int                     grants[$];
    int                     civ_cycles = 0;

    function automatic int next_turn(input logic [NUM_REQ-1:0] v, input int start);
        for (int k = 0; k < NUM_REQ; k++)
            if (v[(start + k) % NUM_REQ]) return (start + k) % NUM_REQ;
        return -1;
    endfunction

    function automatic bit len_ok(input logic [LEN_WIDTH-1:0] l);
        return (int'(l) >= 1) && (int'(l) <= MAX_LEN);
    endfunction

    initial begin : compare
        int w;
        logic [NUM_REQ-1:0] exp_rr, exp_rv;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_stage = 0; m_ptr = 0; m_gid = 0;
                m_ref = '0; m_read = '0; m_rl = '0; m_dl = '0;
                m_score = '0; m_row = '0; m_col = '0; m_err = 1'b0;
                check("rst req_ready", req_ready, '0);
                check("rst rsp_valid", rsp_valid, '0);
                check("rst core_i_valid", core_i_valid, 1'b0);
                check("rst core_i_ready", core_i_ready, 1'b0);
                check("rst busy", busy, 1'b0);
                check("rst grant_id", grant_id, '0);
                check("rst core_ref", core_ref, '0);
                check("rst core_read_len", core_read_len, '0);
                check("rst rsp_score", rsp_score, '0);
                check("rst rsp_err", rsp_err, 1'b0);
            end else begin
                w = next_turn(req_valid, m_ptr);
                exp_rr = '0;
                if (m_stage == 0 && w >= 0) exp_rr[w] = 1'b1;
                exp_rv = '0;
                if (m_stage == 3) exp_rv[m_gid] = 1'b1;
                check("req_ready", req_ready, exp_rr);
                check("rsp_valid", rsp_valid, exp_rv);
                check("core_i_valid", core_i_valid, m_stage == 1);
                check("core_i_ready", core_i_ready, m_stage == 2);
                check("busy", busy, m_stage != 0);
                check("grant_id", grant_id, m_gid);
                check("core_ref", core_ref, m_ref);
                check("core_read", core_read, m_read);
                check("core_ref_len", core_ref_len, m_rl);
                check("core_read_len", core_read_len, m_dl);
                if (m_stage == 3) begin
                    check("rsp_score", rsp_score, m_score);
                    check("rsp_row", rsp_row, m_row);
                    check("rsp_col", rsp_col, m_col);
                    check("rsp_err", rsp_err, m_err);
                end
                if (core_i_valid) civ_cycles++;
                case (m_stage)
                    0: if (w >= 0) begin
                        m_gid  = w;
                        grants.push_back(w);
                        m_ref  = req_ref [w*SEQ_WIDTH +: SEQ_WIDTH];
                        m_read = req_read[w*SEQ_WIDTH +: SEQ_WIDTH];
                        m_rl   = req_ref_len [w*LEN_WIDTH +: LEN_WIDTH];
                        m_dl   = req_read_len[w*LEN_WIDTH +: LEN_WIDTH];
                        if (len_ok(m_rl) && len_ok(m_dl)) begin
                            m_stage = 1; m_err = 1'b0;
                        end else begin
                            m_stage = 3; m_err = 1'b1;
                            m_score = '0; m_row = '0; m_col = '0;
                        end
                    end
                    1: if (core_o_ready) m_stage = 2;
                    2: if (core_o_valid) begin
                        m_score = core_score; m_row = core_row; m_col = core_col;
                        m_stage = 3;
                    end
                    3: if (rsp_ready[m_gid]) begin
                        m_stage = 0;
                        m_ptr   = (m_gid + 1) % NUM_REQ;
                    end
                    default: m_stage = 0;
                endcase
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SEQ_WIDTH-1:0] rnd_seq();
        logic [SEQ_WIDTH-1:0] r;
        for (int k = 0; k < SEQ_WIDTH/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic load_payload(input int i, input int rl, input int dl);
        req_ref [i*SEQ_WIDTH +: SEQ_WIDTH] = rnd_seq();
        req_read[i*SEQ_WIDTH +: SEQ_WIDTH] = rnd_seq();
        req_ref_len [i*LEN_WIDTH +: LEN_WIDTH] = LEN_WIDTH'(rl);
        req_read_len[i*LEN_WIDTH +: LEN_WIDTH] = LEN_WIDTH'(dl);
    endtask

    // Waits (bounded) for any req_ready; returns at accept edge + 1.
    task automatic wait_grant(output int gid);
        bit got;
        got = 1'b0;
        gid = -1;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++)
                if (req_ready[i] && !got) begin gid = i; got = 1'b1; end
        end
        check("grant within 50 cycles", got, 1'b1);
        if (got) cyc();
    endtask

    task automatic run_job(input logic [NUM_REQ-1:0] mask, input int rl, input int dl,
                           input logic [SCORE_WIDTH-1:0] sc, input int row, input int col,
                           input int rdy_dly, input int lat, input int rsp_dly,
                           input bit drop_own, output int gid,
                           output logic [NUM_REQ-1:0] s_rv,
                           output logic [SCORE_WIDTH-1:0] s_sc, output logic s_err);
        logic [NUM_REQ-1:0] own;
        s_rv = '0; s_sc = '0; s_err = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) if (mask[i]) load_payload(i, rl, dl);
        req_valid = req_valid | mask;
        wait_grant(gid);
        if (gid < 0) return;
        own = '0;
        own[gid] = 1'b1;
        if (drop_own) req_valid[gid] = 1'b0;
        // Requester reuses its buffers after accept; the latched copy must hold.
        load_payload(gid, $urandom_range(255), $urandom_range(255));
        if (rl >= 1 && rl <= MAX_LEN && dl >= 1 && dl <= MAX_LEN) begin
            core_o_ready = 1'b0;
            repeat (rdy_dly) cyc();
            core_o_ready = 1'b1;
            cyc();
            core_o_ready = 1'b0;
            repeat (lat) cyc();
            core_o_valid = 1'b1;
            core_score = sc; core_row = POS_WIDTH'(row); core_col = POS_WIDTH'(col);
            cyc();
            core_o_valid = 1'b0;
            core_score = SCORE_WIDTH'($urandom); core_row = '0; core_col = '1;
        end
        @(negedge clk);
        s_rv = rsp_valid; s_sc = rsp_score; s_err = rsp_err;
        cyc();
        rsp_ready = ~own;          // other indices must be ignored
        repeat (rsp_dly) cyc();
        rsp_ready = own;
        cyc();
        rsp_ready = '0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500us");
        $fatal(1);
    end

    initial begin : stim
        int gid, civ0;
        int cnt[NUM_REQ];
        int exp_order[5];
        logic [NUM_REQ-1:0] rv;
        logic [SCORE_WIDTH-1:0] sc;
        logic er;

        rst_n = 1'b0;
        req_valid = '0; rsp_ready = '0;
        req_ref = '0; req_read = '0; req_ref_len = '0; req_read_len = '0;
        core_o_ready = 1'b0; core_o_valid = 1'b0;
        core_score = '0; core_row = '0; core_col = '0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();

        // Single legal job from req0.
        run_job(4'b0001, 128, 128, 10'd37, 127, 127, 0, 2, 0, 1'b1, gid, rv, sc, er);
        check("single gid", gid, 0);
        check("single rsp_valid", rv, 4'b0001);
        check("single rsp_score", sc, 10'd37);
        check("single rsp_err", er, 1'b0);

        // rr_ptr is now 1: with req0 and req1 pending, req1 wins.
        run_job(4'b0011, 10, 20, 10'd5, 3, 9, 0, 1, 0, 1'b1, gid, rv, sc, er);
        check("rr_ptr after req0", gid, 1);
        req_valid = '0;

        // Contention from a fresh reset, all requesters holding valid.
        rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        grants.delete();
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
        for (int j = 0; j < 5; j++) begin
            run_job(4'b1111, 20 + j*10, 30 + j, SCORE_WIDTH'(j*7 + 1), j, j + 2,
                    j % 2, j, 0, 1'b0, gid, rv, sc, er);
            check("contention grant order", gid, exp_order[j]);
            if (j < 4 && gid >= 0) cnt[gid]++;
        end
        req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) check("served once per 4 jobs", cnt[i], 1);
        check("model grant count", grants.size(), 5);
        for (int j = 0; j < grants.size() && j < 5; j++)
            check("model grant order", grants[j], exp_order[j]);

        // Length error on req2: core skipped, response one cycle after accept.
        civ0 = civ_cycles;
        run_job(4'b0100, 0, 50, 10'd99, 1, 1, 0, 0, 0, 1'b1, gid, rv, sc, er);
        check("lenerr gid", gid, 2);
        check("lenerr rsp_valid", rv, 4'b0100);
        check("lenerr rsp_err", er, 1'b1);
        check("lenerr rsp_score", sc, '0);
        check("lenerr core_i_valid cycles", civ_cycles - civ0, 0);

        // Upper boundary: 129 is illegal, 1 and 128 are legal.
        run_job(4'b0001, 64, 129, 10'd1, 1, 1, 0, 0, 0, 1'b1, gid, rv, sc, er);
        check("len 129 rsp_err", er, 1'b1);
        run_job(4'b0010, 1, 128, 10'd2, 0, 127, 0, 0, 0, 1'b1, gid, rv, sc, er);
        check("len 1/128 rsp_err", er, 1'b0);
        check("len 1/128 rsp_score", sc, 10'd2);

        // Backpressure on both sides, other requesters pending throughout.
        run_job(4'b1111, 64, 100, 10'd200, 63, 99, 10, 3, 5, 1'b1, gid, rv, sc, er);
        check("backpressure rsp_score", sc, 10'd200);
        req_valid = '0;

        // Negative score passes through unchanged.
        run_job(4'b0010, 40, 40, 10'h3F4, 39, 12, 1, 0, 1, 1'b1, gid, rv, sc, er);
        check("negative rsp_score", sc, 10'h3F4);
        check("negative rsp_err", er, 1'b0);

        // Reset while the core is computing aborts the job.
        load_payload(1, 30, 30);
        req_valid = 4'b0010;
        wait_grant(gid);
        req_valid = '0;
        core_o_ready = 1'b1;
        cyc();
        core_o_ready = 1'b0;
        cyc();
        check("pre-reset in WAIT", core_i_ready, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid-reset busy", busy, 1'b0);
        check("mid-reset core_i_ready", core_i_ready, 1'b0);
        check("mid-reset grant_id", grant_id, '0);
        check("mid-reset core_ref", core_ref, '0);
        cyc();
        rst_n = 1'b1;
        cyc();
        run_job(4'b1000, 50, 60, 10'd11, 4, 5, 0, 1, 0, 1'b1, gid, rv, sc, er);
        check("after reset gid", gid, 3);
        check("after reset rsp_valid", rv, 4'b1000);
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_core_arbiter.md
Name: sw_core_arbiter

Overview:
- Shares one SW_core instance among NUM_REQ independent requesters, such as several host-link wrappers or on-chip job sources.
- Grants jobs round-robin and latches the winner's sequences and lengths.
- Drives the core's input handshake, captures the core's result, and returns it to the granted requester only.
- Sits between the requester-side wrappers and SW_core; exactly one job is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SEQ_WIDTH, 256, bits per packed sequence (2 bits/base x 128 bases).
- LEN_WIDTH, 8, width of length fields; holds $clog2(MAX_LEN)+1 bits.
- MAX_LEN, 128, largest legal sequence length in bases.
- POS_WIDTH, 7, row/column index width.
- SCORE_WIDTH, 10, signed alignment score width.

Ports:
- clk  in  1  single clock for the block.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester job valid.
- req_ready  out  NUM_REQ  per-requester job accept, one-hot or zero.
- req_ref  in  NUM_REQ*SEQ_WIDTH  packed reference sequences.
- req_read  in  NUM_REQ*SEQ_WIDTH  packed read sequences.
- req_ref_len  in  NUM_REQ*LEN_WIDTH  reference lengths.
- req_read_len  in  NUM_REQ*LEN_WIDTH  read lengths.
- rsp_valid  out  NUM_REQ  per-requester result valid, one-hot or zero.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_score  out  SCORE_WIDTH  signed score, shared bus.
- rsp_row  out  POS_WIDTH  end row, shared bus.
- rsp_col  out  POS_WIDTH  end column, shared bus.
- rsp_err  out  1  length error flag, shared bus.
- core_i_valid  out  1  job valid to core.
- core_o_ready  in  1  core can accept a job.
- core_ref, core_read  out  SEQ_WIDTH  latched sequences.
- core_ref_len, core_read_len  out  LEN_WIDTH  latched lengths.
- core_i_ready  out  1  arbiter can accept a result.
- core_o_valid  in  1  core result valid.
- core_score, core_row, core_col  in  SCORE_WIDTH/POS_WIDTH/POS_WIDTH  core result.
- busy  out  1  high whenever the state is not IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last grantee.

Behaviour:
- Reset (rst_n low, async):
  - State IDLE, rr_ptr=0, grant_id=0.
  - All valid/ready outputs 0; result and payload registers 0; busy 0.
  - SW_core is reset by the same reset, inverted at the top level.
- IDLE:
  - Winner = first index with req_valid set, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[winner]=1 combinationally for that cycle only.
  - On accept: latch payload and grant_id=winner.
  - If either length is 0 or greater than MAX_LEN: load score/row/col=0, rsp_err=1, go to RESP; the core is skipped.
  - Otherwise: rsp_err=0, go to ISSUE.
  - No req_valid set: stay in IDLE, all req_ready 0.
- ISSUE:
  - core_i_valid=1; core_* payload is stable from the latched registers.
  - core_o_ready & core_i_valid: go to WAIT; core_i_valid drops the next cycle.
- WAIT:
  - core_i_ready=1.
  - core_o_valid: capture score/row/col, go to RESP; core_i_ready drops the next cycle.
- RESP:
  - rsp_valid[grant_id]=1 and rsp_* held stable.
  - rsp_ready[grant_id]: go to IDLE, rr_ptr=(grant_id+1) mod NUM_REQ.
  - rsp_ready on any other index is ignored.
- req_ready is 0 in every state except IDLE, so new requests are held off while a job is in flight.
- Latency for a legal job, with immediate core ready and requester ready: accept cycle -> ISSUE 1 cycle -> WAIT (core latency) -> RESP 1 cycle.
- Minimum request-to-request spacing: 3 cycles plus core latency.
- An error job returns its response 1 cycle after accept.
- Requester payload may change after accept; the latched copy is used.
- rsp_score is a sign-preserving copy, no extension.
- Reset asserted mid-job aborts the job with no response; requesters must reissue.

Decomposition:
- Shared package sw_pkg holds:
  - constants REF_MAX_LENGTH, READ_MAX_LENGTH, DP_SW_SCORE_BITWIDTH;
  - typedef sw_job_t (ref, read, ref_len, read_len);
  - typedef sw_result_t (score, row, col, err);
  - arbiter state enum.
- One natural sub-module: sw_rr_picker, a combinational round-robin priority select (req vector, rr_ptr -> one-hot grant, index, any).

Test Plan:
- Single job: req0 with lengths 128/128, core returns score=37 row=127 col=127 -> rsp_valid=4'b0001, rsp_score=37, rsp_err=0, rr_ptr=1.
- Contention: req_valid=4'b1111 held, each request reissued after its response -> grant order 0,1,2,3,0; each requester served exactly once per 4 jobs.
- Length error: req2 with ref_len=0 -> core_i_valid never asserts; rsp_valid=4'b0100 one cycle after accept, rsp_err=1, score 0.
- Backpressure: core_o_ready low 10 cycles, then rsp_ready low 5 cycles -> core_i_valid and rsp_valid/rsp_* held stable; no new req_ready during the wait.
- Negative score: core returns score=-12 (10'h3F4) -> rsp_score=10'h3F4.
- Reset mid-WAIT: rst_n low for 1 cycle -> all outputs 0 immediately; next job from req3 is granted first because rr_ptr=0 and only req3 is valid.
